// File: rtl/bpm_test_link_arbiter.sv
// bpm_test_link_arbiter: packet-granular round-robin arbiter that shares one
// Aurora BPM test AXI-stream TX link among NUM_SRC packet sources. Each source
// may send one packet per FA cycle. Credits refresh on auroraFAstrobe. A packet
// cut off by channel loss is drained from its source and discarded.
// Optional per-source packet counters: define BPM_TEST_LINK_ARB_STATS_EN.
module bpm_test_link_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          auroraUserClk,
  input  logic                          auroraUserReset_n,
  input  logic                          auroraFAstrobe,
  input  logic                          auroraChannelUp,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] SRC_AXI_STREAM_tdata,
  input  logic [NUM_SRC-1:0]            SRC_AXI_STREAM_tvalid,
  input  logic [NUM_SRC-1:0]            SRC_AXI_STREAM_tlast,
  output logic [NUM_SRC-1:0]            SRC_AXI_STREAM_tready,
  output logic [DATA_WIDTH-1:0]         TX_AXI_STREAM_tdata,
  output logic                          TX_AXI_STREAM_tvalid,
  output logic                          TX_AXI_STREAM_tlast,
  input  logic                          TX_AXI_STREAM_tready,
  output logic [IDX_WIDTH-1:0]          grantIdx,
  output logic                          busy,
`ifdef BPM_TEST_LINK_ARB_STATS_EN
  output logic [NUM_SRC*16-1:0]         pktCount,
`endif
  output logic [15:0]                   dropCount
);

  typedef enum logic [1:0] {IDLE, XFER, FLUSH} state_t;

  state_t                  state, stateNext;
  logic [NUM_SRC-1:0]      credit;
  logic [NUM_SRC-1:0]      eligible;
  logic [IDX_WIDTH-1:0]    lastGrant;
  logic [IDX_WIDTH-1:0]    pickIdx;
  logic                    pickValid;
  int unsigned             cand;
  logic [DATA_WIDTH-1:0]   selData;
  logic                    selValid;
  logic                    selLast;
  logic                    pktDone;
  logic                    pktSent;
  logic                    dropEvent;

  // Round-robin search: first eligible source starting after lastGrant.
  always_comb begin
    eligible  = SRC_AXI_STREAM_tvalid & credit & {NUM_SRC{auroraChannelUp}};
    pickValid = 1'b0;
    pickIdx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = (32'(lastGrant) + k) % NUM_SRC;
      if (!pickValid && eligible[cand]) begin
        pickValid = 1'b1;
        pickIdx   = IDX_WIDTH'(cand);
      end
    end
  end

  // Source mux selected by the registered grant.
  always_comb begin
    selData  = '0;
    selValid = 1'b0;
    selLast  = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grantIdx == IDX_WIDTH'(i)) begin
        selData  = SRC_AXI_STREAM_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        selValid = SRC_AXI_STREAM_tvalid[i];
        selLast  = SRC_AXI_STREAM_tlast[i];
      end
    end
  end

  // Next-state and handshake outputs. With the channel down in XFER both the
  // TX side and the source are held off, so the beat on the bus stays with the
  // source and is drained by FLUSH; a same-cycle tlast therefore never ends the
  // packet twice.
  always_comb begin
    stateNext             = state;
    SRC_AXI_STREAM_tready = '0;
    TX_AXI_STREAM_tdata   = '0;
    TX_AXI_STREAM_tvalid  = 1'b0;
    TX_AXI_STREAM_tlast   = 1'b0;
    pktDone               = 1'b0;
    pktSent               = 1'b0;
    dropEvent             = 1'b0;
    case (state)
      IDLE: begin
        if (pickValid) stateNext = XFER;
      end
      XFER: begin
        if (!auroraChannelUp) begin
          dropEvent = 1'b1;
          stateNext = FLUSH;
        end else begin
          TX_AXI_STREAM_tdata             = selData;
          TX_AXI_STREAM_tvalid            = selValid;
          TX_AXI_STREAM_tlast             = selLast;
          SRC_AXI_STREAM_tready[grantIdx] = TX_AXI_STREAM_tready;
          if (selValid && TX_AXI_STREAM_tready && selLast) begin
            pktDone   = 1'b1;
            pktSent   = 1'b1;
            stateNext = IDLE;
          end
        end
      end
      FLUSH: begin
        SRC_AXI_STREAM_tready[grantIdx] = 1'b1;
        if (selValid && selLast) begin
          pktDone   = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // State, grant and round-robin pointer registers.
  always_ff @(posedge auroraUserClk or negedge auroraUserReset_n) begin
    if (!auroraUserReset_n) begin
      state     <= IDLE;
      grantIdx  <= '0;
      lastGrant <= IDX_WIDTH'(NUM_SRC - 1);
    end else begin
      state <= stateNext;
      if (state == IDLE && pickValid) grantIdx <= pickIdx;
      if (pktDone) lastGrant <= grantIdx;
    end
  end

  // Credits: strobe refreshes all and wins over a same-cycle clear.
  always_ff @(posedge auroraUserClk or negedge auroraUserReset_n) begin
    if (!auroraUserReset_n) begin
      credit <= '0;
    end else if (auroraFAstrobe) begin
      credit <= '1;
    end else if (pktDone) begin
      credit[grantIdx] <= 1'b0;
    end
  end

  // Saturating count of packets aborted by channel loss.
  always_ff @(posedge auroraUserClk or negedge auroraUserReset_n) begin
    if (!auroraUserReset_n) begin
      dropCount <= '0;
    end else if (dropEvent && dropCount != 16'hFFFF) begin
      dropCount <= dropCount + 16'd1;
    end
  end

`ifdef BPM_TEST_LINK_ARB_STATS_EN
  // Per-source wrapping count of packets delivered on the link.
  always_ff @(posedge auroraUserClk or negedge auroraUserReset_n) begin
    if (!auroraUserReset_n) begin
      pktCount <= '0;
    end else if (pktSent) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (grantIdx == IDX_WIDTH'(i)) pktCount[i*16 +: 16] <= pktCount[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bpm_test_link_arbiter.sv
// Testbench for bpm_test_link_arbiter with two sources: a per-cycle vector
// table for grant/round-robin behaviour, then directed sequences for
// backpressure, channel loss and strobe/tlast coincidence.
module tb_bpm_test_link_arbiter;

  localparam int NS = 2;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          strobe;
  logic          chUp;
  logic [DW-1:0] d0, d1;
  logic [NS*DW-1:0] srcData;
  logic [NS-1:0] srcValid, srcLast, srcReady;
  logic [DW-1:0] txData;
  logic          txValid, txLast, txReady;
  logic          grant;
  logic          busy;
  logic [15:0]   dropCount;
`ifdef BPM_TEST_LINK_ARB_STATS_EN
  logic [NS*16-1:0] pktCount;
`endif

  int passCnt  = 0;
  int totalCnt = 0;
  int k;

  always #5 clk = ~clk;
  assign srcData = {d1, d0};

  bpm_test_link_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW)) dut (
    .auroraUserClk         (clk),
    .auroraUserReset_n     (rst_n),
    .auroraFAstrobe        (strobe),
    .auroraChannelUp       (chUp),
    .SRC_AXI_STREAM_tdata  (srcData),
    .SRC_AXI_STREAM_tvalid (srcValid),
    .SRC_AXI_STREAM_tlast  (srcLast),
    .SRC_AXI_STREAM_tready (srcReady),
    .TX_AXI_STREAM_tdata   (txData),
    .TX_AXI_STREAM_tvalid  (txValid),
    .TX_AXI_STREAM_tlast   (txLast),
    .TX_AXI_STREAM_tready  (txReady),
    .grantIdx              (grant),
    .busy                  (busy),
`ifdef BPM_TEST_LINK_ARB_STATS_EN
    .pktCount              (pktCount),
`endif
    .dropCount             (dropCount)
  );

  typedef struct {
    logic        strobe;
    logic        up;
    logic [1:0]  valid;
    logic [1:0]  last;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        rdy;
    logic        eValid;
    logic        eLast;
    logic [31:0] eData;
    logic [1:0]  eReady;
    logic        eGrant;
    logic        eBusy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(logic s, logic u, logic [1:0] v, logic [1:0] l,
                                 logic [31:0] a, logic [31:0] b, logic r,
                                 logic ev, logic el, logic [31:0] ed,
                                 logic [1:0] er, logic eg, logic eb);
    vec_t t;
    t = '{s, u, v, l, a, b, r, ev, el, ed, er, eg, eb};
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #4;
  endtask

  initial begin
    rst_n    = 1'b0;
    strobe   = 1'b0;
    chUp     = 1'b1;
    srcValid = 2'b11;
    srcLast  = 2'b00;
    d0       = 32'hDEAD0000;
    d1       = 32'hDEAD0001;
    txReady  = 1'b1;

    // Reset values with sources asserting valid.
    #12;
    check("rst.txValid", txValid, 0);
    check("rst.txLast", txLast, 0);
    check("rst.txData", txData, 0);
    check("rst.srcReady", srcReady, 0);
    check("rst.busy", busy, 0);
    check("rst.grant", grant, 0);
    check("rst.dropCount", dropCount, 0);
    srcValid = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nextCycle();

    // Per-cycle vectors: inputs during a cycle, expected outputs in that cycle.
    vecs.push_back(mkVec(1,1,2'b00,2'b00,0,0,1,           0,0,0,2'b00,0,0));
    vecs.push_back(mkVec(0,1,2'b01,2'b00,32'hA0,0,1,      0,0,0,2'b00,0,0));
    vecs.push_back(mkVec(0,1,2'b01,2'b00,32'hA0,0,1,      1,0,32'hA0,2'b01,0,1));
    vecs.push_back(mkVec(0,1,2'b01,2'b00,32'hA1,0,0,      1,0,32'hA1,2'b00,0,1));
    vecs.push_back(mkVec(0,1,2'b01,2'b00,32'hA1,0,1,      1,0,32'hA1,2'b01,0,1));
    vecs.push_back(mkVec(0,1,2'b01,2'b00,32'hA2,0,1,      1,0,32'hA2,2'b01,0,1));
    vecs.push_back(mkVec(0,1,2'b01,2'b01,32'hA3,0,1,      1,1,32'hA3,2'b01,0,1));
    vecs.push_back(mkVec(0,1,2'b01,2'b00,32'hB0,0,1,      0,0,0,2'b00,0,0));
    vecs.push_back(mkVec(0,1,2'b01,2'b00,32'hB0,0,1,      0,0,0,2'b00,0,0));
    vecs.push_back(mkVec(1,1,2'b01,2'b01,32'hB0,0,1,      0,0,0,2'b00,0,0));
    vecs.push_back(mkVec(0,1,2'b01,2'b01,32'hB0,0,1,      0,0,0,2'b00,0,0));
    vecs.push_back(mkVec(0,1,2'b01,2'b01,32'hB0,0,1,      1,1,32'hB0,2'b01,0,1));
    vecs.push_back(mkVec(1,1,2'b00,2'b00,0,0,1,           0,0,0,2'b00,0,0));
    vecs.push_back(mkVec(0,1,2'b11,2'b00,32'hC0,32'hD0,1, 0,0,0,2'b00,0,0));
    vecs.push_back(mkVec(0,1,2'b11,2'b00,32'hC0,32'hD0,1, 1,0,32'hD0,2'b10,1,1));
    vecs.push_back(mkVec(0,1,2'b11,2'b10,32'hC0,32'hD1,1, 1,1,32'hD1,2'b10,1,1));
    vecs.push_back(mkVec(0,1,2'b11,2'b11,32'hC0,32'hD2,1, 0,0,0,2'b00,1,0));
    vecs.push_back(mkVec(0,1,2'b11,2'b11,32'hC0,32'hD2,1, 1,1,32'hC0,2'b01,0,1));
    vecs.push_back(mkVec(0,1,2'b11,2'b11,32'hC1,32'hD2,1, 0,0,0,2'b00,0,0));
    vecs.push_back(mkVec(1,1,2'b11,2'b11,32'hC1,32'hD2,1, 0,0,0,2'b00,0,0));
    vecs.push_back(mkVec(0,1,2'b11,2'b11,32'hC1,32'hD2,1, 0,0,0,2'b00,0,0));
    vecs.push_back(mkVec(0,1,2'b11,2'b11,32'hC1,32'hD2,1, 1,1,32'hD2,2'b10,1,1));
    vecs.push_back(mkVec(0,1,2'b00,2'b00,0,0,1,           0,0,0,2'b00,1,0));

    foreach (vecs[i]) begin
      strobe   = vecs[i].strobe;
      chUp     = vecs[i].up;
      srcValid = vecs[i].valid;
      srcLast  = vecs[i].last;
      d0       = vecs[i].d0;
      d1       = vecs[i].d1;
      txReady  = vecs[i].rdy;
      settle();
      check($sformatf("v%0d.txValid", i), txValid, vecs[i].eValid);
      check($sformatf("v%0d.txLast", i), txLast, vecs[i].eLast);
      check($sformatf("v%0d.txData", i), txData, vecs[i].eData);
      check($sformatf("v%0d.srcReady", i), srcReady, vecs[i].eReady);
      check($sformatf("v%0d.grant", i), grant, vecs[i].eGrant);
      check($sformatf("v%0d.busy", i), busy, vecs[i].eBusy);
      nextCycle();
    end

    // Backpressure: src0 (credit left over) sends 8 words under random tready.
    strobe = 0; srcValid = 2'b01; srcLast = 2'b00; d0 = 32'h1000; d1 = 0;
    settle();
    check("bp.idleBusy", busy, 0);
    nextCycle();
    k = 0;
    for (int c = 0; c < 200 && k < 8; c++) begin
      txReady    = 1'($urandom_range(0, 1));
      d0         = 32'h1000 + k;
      srcLast[0] = (k == 7);
      settle();
      check("bp.txValid", txValid, 1);
      check("bp.txData", txData, 32'h1000 + k);
      check("bp.txLast", txLast, (k == 7) ? 1 : 0);
      check("bp.srcReady", srcReady, {1'b0, txReady});
      check("bp.grant", grant, 0);
      if (txReady) k++;
      nextCycle();
    end
    check("bp.allBeats", k, 8);
    srcValid = 2'b00; srcLast = 2'b00; txReady = 1'b1;
    settle();
    check("bp.endBusy", busy, 0);
    nextCycle();

    // Channel down before grant: strobes run, nothing may be granted.
    chUp = 0; srcValid = 2'b11; srcLast = 2'b11; d0 = 32'h2000; d1 = 32'h3000;
    for (int c = 0; c < 6; c++) begin
      strobe = (c == 1 || c == 4);
      settle();
      check("cd.txValid", txValid, 0);
      check("cd.busy", busy, 0);
      nextCycle();
    end
    strobe = 0; chUp = 1;
    settle();
    check("cd.upIdle", busy, 0);
    nextCycle();
    settle();
    check("cd.grantBusy", busy, 1);
    check("cd.grant", grant, 1);
    check("cd.txValid", txValid, 1);
    check("cd.txData", txData, 32'h3000);
    check("cd.txLast", txLast, 1);
    nextCycle();
    srcValid = 2'b00; srcLast = 2'b00;

    // Channel drop after word 2 of 5 from src0.
    srcValid = 2'b01; d0 = 32'h4000;
    settle();
    check("dr.idle", busy, 0);
    nextCycle();
    for (int w = 0; w < 2; w++) begin
      d0 = 32'h4000 + w;
      settle();
      check("dr.txValid", txValid, 1);
      check("dr.txData", txData, 32'h4000 + w);
      nextCycle();
    end
    chUp = 0; d0 = 32'h4002;
    settle();
    check("dr.dropTxValid", txValid, 0);
    check("dr.dropBusy", busy, 1);
    nextCycle();
    for (int w = 2; w < 5; w++) begin
      d0 = 32'h4000 + w; srcLast[0] = (w == 4);
      settle();
      check("dr.flushTxValid", txValid, 0);
      check("dr.flushReady", srcReady, 2'b01);
      check("dr.flushBusy", busy, 1);
      nextCycle();
    end
    chUp = 1; srcValid = 2'b00; srcLast = 2'b00;
    settle();
    check("dr.endBusy", busy, 0);
    check("dr.dropCount", dropCount, 1);
    nextCycle();
    // Next strobe resumes normal grants.
    strobe = 1;
    nextCycle();
    strobe = 0; srcValid = 2'b01; srcLast = 2'b01; d0 = 32'h5000;
    settle();
    check("rs.idle", busy, 0);
    nextCycle();
    settle();
    check("rs.txValid", txValid, 1);
    check("rs.txData", txData, 32'h5000);
    check("rs.grant", grant, 0);
    nextCycle();
    srcValid = 2'b00; srcLast = 2'b00;

    // Strobe coincident with src0 tlast: credit must survive for a new packet.
    strobe = 1;
    nextCycle();
    strobe = 0; srcValid = 2'b01; d0 = 32'h6000;
    nextCycle();
    settle();
    check("st.word1", txData, 32'h6000);
    nextCycle();
    strobe = 1; d0 = 32'h6001; srcLast = 2'b01;
    settle();
    check("st.word2", txData, 32'h6001);
    check("st.txLast", txLast, 1);
    nextCycle();
    strobe = 0; d0 = 32'h7000;
    settle();
    check("st.idle", busy, 0);
    nextCycle();
    settle();
    check("st.regrantBusy", busy, 1);
    check("st.regrantData", txData, 32'h7000);
    check("st.regrantValid", txValid, 1);
    nextCycle();
    srcValid = 2'b00; srcLast = 2'b00;
    settle();
    check("st.endBusy", busy, 0);
    check("end.dropCount", dropCount, 1);
`ifdef BPM_TEST_LINK_ARB_STATS_EN
    check("end.pktCount0", pktCount[15:0], 7);
    check("end.pktCount1", pktCount[31:16], 3);
`endif

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
